// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM state encoding, default width, divide-by-zero constants.
// Latency: n/a (package).
// Backpressure: n/a (package).
package alu_pkg;

    // Divider FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divu_state_t;

    localparam int DIV_WIDTH_DEFAULT = 32;

    // Divide-by-zero result: every quotient bit takes DBZ_Q_FILL (all-ones quotient),
    // and the remainder is the untouched dividend.
    localparam logic DBZ_Q_FILL = 1'b1;

endpackage

// File: rtl/divu_seq_if.sv
// Operand/result bundle for the sequential unsigned divider.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
//   master: issues A/B with in_valid, raises flush, consumes Q/R/dbz with out_ready.
//   slave : the divider itself.
interface divu_seq_if #(
    parameter int WIDTH = alu_pkg::DIV_WIDTH_DEFAULT
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             dbz;

    modport master (
        output in_valid, A, B, flush, out_ready,
        input  in_ready, out_valid, Q, R, dbz
    );

    modport slave (
        input  in_valid, A, B, flush, out_ready,
        output in_ready, out_valid, Q, R, dbz
    );
endinterface

// File: rtl/divu_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, restore on borrow.
// Latency: combinational.
// Backpressure: none.
//   rem_lo  : low WIDTH bits of the partial remainder
//   dq      : dividend/quotient shift register
//   b       : divisor
//   rem_nxt : partial remainder after this step (WIDTH+1 bits)
//   dq_nxt  : shift register with the new quotient bit appended
module divu_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_lo,
    input  logic [WIDTH-1:0] dq,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   rem_nxt,
    output logic [WIDTH-1:0] dq_nxt
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           borrow;

    assign shifted = {rem_lo, dq[WIDTH-1]};

    // Borrow-out subtractor: one extra bit on top catches the borrow of the (WIDTH+1)-bit subtract.
    assign {borrow, diff} = {1'b0, shifted} - {2'b00, b};

    // No borrow means shifted >= b: keep the difference and emit a 1 quotient bit.
    assign rem_nxt = borrow ? shifted : diff;
    assign dq_nxt  = {dq[WIDTH-2:0], ~borrow};
endmodule

// File: rtl/divu_seq.sv
// Sequential unsigned divider (DIVU/REMU), one restoring step per clock via divu_step.
// Latency: out_valid WIDTH+1 edges after acceptance, 1 edge for divide-by-zero.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; flush aborts anything.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : divu_seq_if slave (in_valid/in_ready/A/B/flush, out_valid/out_ready/Q/R/dbz)
module divu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    divu_seq_if.slave   bus
);
    divu_state_t      state;
    divu_state_t      state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dq;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] b_q;

    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] r_q;
    logic             dbz_q;

    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_dq;

    logic             accept;
    logic             b_zero;
    logic             last_step;

    // in_ready is a register so it reads 0 throughout reset and only rises on the first edge after.
    assign accept    = (state == IDLE) && in_ready_q && bus.in_valid;
    assign b_zero    = (bus.B == '0);
    assign last_step = (cnt == '0);

    divu_step #(.WIDTH(WIDTH)) u_step (
        .rem_lo  (rem[WIDTH-1:0]),
        .dq      (dq),
        .b       (b_q),
        .rem_nxt (step_rem),
        .dq_nxt  (step_dq)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (accept) state_nxt = b_zero ? DONE : BUSY;
                BUSY: if (last_step) state_nxt = DONE;
                // Leave only once the consumer has actually seen out_valid.
                DONE: if (out_valid_q && bus.out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // out_valid trails entry into DONE by one edge, so the first DONE cycle is where the
    // result registers settle; a handshake can only happen from the second DONE cycle on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= (state_nxt == IDLE);
            out_valid_q <= (state == DONE) && (state_nxt == DONE);
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            dq    <= '0;
            rem   <= '0;
            b_q   <= '0;
            q_q   <= '0;
            r_q   <= '0;
            dbz_q <= 1'b0;
        end else if (!bus.flush) begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        dq  <= bus.A;
                        b_q <= bus.B;
                        rem <= '0;
                        cnt <= CNT_W'(WIDTH - 1);
                        if (b_zero) begin
                            q_q   <= {WIDTH{DBZ_Q_FILL}};
                            r_q   <= bus.A;
                            dbz_q <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    dq  <= step_dq;
                    rem <= step_rem;
                    if (last_step) begin
                        q_q   <= step_dq;
                        r_q   <= step_rem[WIDTH-1:0];
                        dbz_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The partial remainder is always below the divisor, so its top bit never sets.
    a_rem_msb_zero: assert property (@(posedge clk) disable iff (!rst_n) rem[WIDTH] == 1'b0);

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.Q         = q_q;
    assign bus.R         = r_q;
    assign bus.dbz       = dbz_q;
endmodule
